// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Single-byte SPI read/write master. Sends a command byte
//            {addr[6:0], rw} then one data byte, MSB first, and returns the
//            byte shifted in on miso during the data phase of a read.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_DIV  : clk cycles per SCLK half-period (>= 2)
//   TURN_CYC : clk cycles of SCLK-low gap between command and data (>= 1)
// Ports
//   clk, reset         : system clock, asynchronous active-high reset
//   start, rw          : request strobe (taken only when idle), 1 = read
//   addr[6:0], wdata   : target address and write data
//   busy, done         : busy from accept through CS-high gap; done pulse
//   rdata[7:0]         : last read result, held until the next read ends
//   sclk, cs, mosi     : SPI outputs (sclk idle low, cs active low)
//   miso               : SPI input
// Build option
//   SPI_MASTER_LOOPBACK_EN : receive shifter samples mosi instead of miso, and
//                            reads transmit wdata so that rdata = wdata.
// ============================================================================
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int TURN_CYC = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam int c_div_w  = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int c_turn_w = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
  localparam logic [c_turn_w-1:0] c_turn_last = c_turn_w'(TURN_CYC - 1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_setup = 3'd1;
  localparam logic [2:0] c_st_cmd   = 3'd2;
  localparam logic [2:0] c_st_turn  = 3'd3;
  localparam logic [2:0] c_st_data  = 3'd4;
  localparam logic [2:0] c_st_hold  = 3'd5;
  localparam logic [2:0] c_st_gap   = 3'd6;

  logic [2:0]          r_state;
  logic [c_div_w-1:0]  r_div;
  logic [c_turn_w-1:0] r_turn;
  logic [2:0]          r_bit;
  logic [7:0]          r_tx;     // outgoing byte, current bit at [7]
  logic [7:0]          r_data;   // data byte queued for the data phase
  logic [7:0]          r_rx;
  logic                r_rw;
  logic                w_div_last;
  logic                w_rx_in;

  assign w_div_last = (r_div == c_div_last);

`ifdef SPI_MASTER_LOOPBACK_EN
  logic w_unused_miso;
  assign w_unused_miso = miso;
  assign w_rx_in       = mosi;
`else
  assign w_rx_in       = miso;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_div   <= '0;
      r_turn  <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_data  <= '0;
      r_rx    <= '0;
      r_rw    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_tx    <= {addr, rw};
`ifdef SPI_MASTER_LOOPBACK_EN
            r_data  <= wdata;
`else
            r_data  <= rw ? 8'h00 : wdata;
`endif
            r_rw    <= rw;
            r_div   <= '0;
            mosi    <= addr[6];
            cs      <= 1'b0;
            busy    <= 1'b1;
            r_state <= c_st_setup;
          end
        end

        c_st_setup: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_bit   <= '0;
            sclk    <= 1'b1;
            r_state <= c_st_cmd;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        // Shared bit engine for both bytes. The sclk register doubles as
        // the phase flag: high phase ends with a sample and a falling edge
        // (mosi advances there), low phase ends with the next rising edge.
        c_st_cmd, c_st_data: begin
          if (!w_div_last) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (sclk) begin
              sclk <= 1'b0;
              if (r_state == c_st_data) begin
                r_rx <= {r_rx[6:0], w_rx_in};
              end
              if (r_bit != 3'd7) begin
                r_tx <= {r_tx[6:0], 1'b0};
                mosi <= r_tx[6];
              end
            end else if (r_bit != 3'd7) begin
              r_bit <= r_bit + 3'd1;
              sclk  <= 1'b1;
            end else if (r_state == c_st_cmd) begin
              r_turn  <= '0;
              r_tx    <= r_data;
              mosi    <= r_data[7];
              r_state <= c_st_turn;
            end else begin
              r_state <= c_st_hold;
            end
          end
        end

        c_st_turn: begin
          if (r_turn == c_turn_last) begin
            r_div   <= '0;
            r_bit   <= '0;
            sclk    <= 1'b1;
            r_state <= c_st_data;
          end else begin
            r_turn <= r_turn + 1'b1;
          end
        end

        c_st_hold: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_bit   <= '0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            done    <= 1'b1;
            if (r_rw) begin
              rdata <= r_rx;
            end
            r_state <= c_st_gap;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        // Two half-period slots; r_bit[0] marks the second one.
        c_st_gap: begin
          if (w_div_last) begin
            r_div <= '0;
            if (r_bit[0]) begin
              r_bit   <= '0;
              busy    <= 1'b0;
              r_state <= c_st_idle;
            end else begin
              r_bit <= 3'd1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: begin
          sclk    <= 1'b0;
          cs      <= 1'b1;
          mosi    <= 1'b0;
          busy    <= 1'b0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Directed self-checking bench for spi_master (default parameters).
//            A clocked monitor captures mosi on each sclk rise; a small slave
//            model drives miso with a chosen byte during the data phase.
// Revision : 1.0 - initial release
// Build option
//   SPI_MASTER_LOOPBACK_EN : read expectations switch to rdata = wdata.
// ============================================================================
module tb_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int TURN_CYC = 8;
`ifdef SPI_MASTER_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw    = 1'b0;
  logic [6:0] addr  = '0;
  logic [7:0] wdata = '0;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;

  spi_master #(
    .CLK_DIV  (CLK_DIV),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .rw    (rw),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .sclk  (sclk),
    .cs    (cs),
    .mosi  (mosi),
    .miso  (miso)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor: sclk rise count and mosi bits, cleared on every cs fall.
  logic        prev_sclk  = 1'b0;
  logic        prev_cs    = 1'b1;
  int          rises      = 0;
  logic [15:0] cap        = '0;
  logic [7:0]  slave_byte = '0;

  always @(posedge clk) begin
    prev_sclk <= sclk;
    prev_cs   <= cs;
    if (prev_cs && !cs) begin
      rises <= 0;
      cap   <= '0;
    end else if (sclk && !prev_sclk) begin
      rises <= rises + 1;
      cap   <= {cap[14:0], mosi};
    end
  end

  // Data bit j is presented once the monitor has counted rise 9+j, i.e.
  // well before the master samples at the end of that high phase.
  always_comb begin
    miso = 1'b0;
    if (rises >= 9 && rises <= 16) begin
      miso = slave_byte[3'(16 - rises)];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int         cyc;
  int         done_cyc;
  int         idle_cyc;
  int         n_done;
  logic       cs1;
  logic       busy1;
  logic       cs_done;
  logic [7:0] rdata_done;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Presents a request at #1 after an edge; the next edge is cycle 0's end.
  task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] d,
                         input logic [7:0] sb, input bit hold);
    slave_byte = sb;
    rw         = r;
    addr       = a;
    wdata      = d;
    start      = 1'b1;
    cyc        = 0;
    tick();
    if (!hold) start = 1'b0;
    cs1        = cs;
    busy1      = busy;
    done_cyc   = -1;
    n_done     = 0;
    cs_done    = 1'b0;
    rdata_done = '0;
    while (busy && cyc < 400) begin
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc   = cyc;
          cs_done    = cs;
          rdata_done = rdata;
        end
      end
      tick();
    end
    idle_cyc = cyc;
  endtask

  initial begin
    // Reset asserted while idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_sclk",  32'(sclk),  32'h0);
    check("rst_cs",    32'(cs),    32'h1);
    check("rst_mosi",  32'(mosi),  32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_rdata", 32'(rdata), 32'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Write 0x2A <- 0xC5
    run_txn(1'b0, 7'h2A, 8'hC5, 8'h00, 1'b0);
    check("wr_cs_cyc1",   32'(cs1),        32'h0);
    check("wr_busy_cyc1", 32'(busy1),      32'h1);
    check("wr_cmd",       32'(cap[15:8]),  32'h54);
    check("wr_data",      32'(cap[7:0]),   32'hC5);
    check("wr_rises",     32'(rises),      32'd16);
    check("wr_done_cyc",  32'(done_cyc),   32'd145);
    check("wr_cs_done",   32'(cs_done),    32'h1);
    check("wr_n_done",    32'(n_done),     32'd1);
    check("wr_idle_cyc",  32'(idle_cyc),   32'd153);
    check("wr_rdata",     32'(rdata),      32'h00);

    // Read 0x15, slave answers 0x3C
    run_txn(1'b1, 7'h15, 8'hA7, 8'h3C, 1'b0);
    check("rd_cmd",        32'(cap[15:8]),  32'h2B);
    check("rd_data_mosi",  32'(cap[7:0]),   LB ? 32'hA7 : 32'h00);
    check("rd_rises",      32'(rises),      32'd16);
    check("rd_done_cyc",   32'(done_cyc),   32'd145);
    check("rd_rdata_done", 32'(rdata_done), LB ? 32'hA7 : 32'h3C);
    check("rd_idle_cyc",   32'(idle_cyc),   32'd153);
    check("rd_rdata_hold", 32'(rdata),      LB ? 32'hA7 : 32'h3C);

    // start held high across a whole write
    run_txn(1'b0, 7'h2A, 8'hC5, 8'h00, 1'b1);
    check("hold_n_done",   32'(n_done),   32'd1);
    check("hold_idle_cyc", 32'(idle_cyc), 32'd153);
    check("hold_rdata",    32'(rdata),    LB ? 32'hA7 : 32'h3C);
    tick();
    start = 1'b0;
    check("hold_reaccept_busy", 32'(busy), 32'h1);
    check("hold_reaccept_cs",   32'(cs),   32'h0);
    cyc = 0;
    while (busy && cyc < 400) tick();
    check("hold_second_idle", 32'(busy), 32'h0);

    // Reset at cycle 60 of a read
    slave_byte = 8'h3C;
    rw         = 1'b1;
    addr       = 7'h15;
    wdata      = 8'hA7;
    start      = 1'b1;
    cyc        = 0;
    tick();
    start = 1'b0;
    while (cyc < 60) tick();
    check("mid_cs_before", 32'(cs), 32'h0);
    #3 reset = 1'b1;
    #1;
    check("mid_cs",    32'(cs),    32'h1);
    check("mid_sclk",  32'(sclk),  32'h0);
    check("mid_mosi",  32'(mosi),  32'h0);
    check("mid_busy",  32'(busy),  32'h0);
    check("mid_rdata", 32'(rdata), 32'h00);
    n_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("mid_no_done",   32'(n_done), 32'd0);
    check("mid_idle_busy", 32'(busy),   32'h0);

    // Fresh write after the aborted read
    run_txn(1'b0, 7'h3F, 8'h81, 8'h00, 1'b0);
    check("fr_cmd",      32'(cap[15:8]), 32'h7E);
    check("fr_data",     32'(cap[7:0]),  32'h81);
    check("fr_done_cyc", 32'(done_cyc),  32'd145);
    check("fr_idle_cyc", 32'(idle_cyc),  32'd153);
    check("fr_rdata",    32'(rdata),     32'h00);

`ifdef SPI_MASTER_LOOPBACK_EN
    // Loopback read with miso held low
    run_txn(1'b1, 7'h01, 8'hA7, 8'h00, 1'b0);
    check("lb_cmd",   32'(cap[15:8]),  32'h03);
    check("lb_data",  32'(cap[7:0]),   32'hA7);
    check("lb_rdata", 32'(rdata_done), 32'hA7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

SPI master that issues single-byte read/write transactions to the SPI memory peripheral over SCLK/CS/MOSI/MISO. It serializes a command byte {address, R/W} followed by one data byte, and collects the returned byte on reads. It sits between the host-side request logic and the off-block SPI pins, with the peripheral's slave FSM at the far end.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range ≥2.
- TURN_CYC, 8: clk cycles of SCLK-low gap between command byte and data byte, giving the slave time to latch the address and load its shift register; legal range ≥1.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; accepted only when busy=0.
- rw  in  1  1 = read, 0 = write.
- addr  in  7  target address.
- wdata  in  8  write data.
- busy  out  1  high from accept through end of CS-high gap.
- done  out  1  one-cycle pulse at transaction end.
- rdata  out  8  read result; holds until next read completes.
- sclk  out  1  SPI clock, idle low.
- cs  out  1  chip select, active low, idle high.
- mosi  out  1  master-out data.
- miso  in  1  slave-out data.

## Operation
- Reset values: sclk=0, cs=1, mosi=0, busy=0, done=0, rdata=0x00; FSM in IDLE.
- Accept: start=1 while busy=0 captures {addr, rw, wdata} and sets busy next cycle. start while busy=1 is ignored.
- Command byte = {addr[6:0], rw}, MSB first. Data byte MSB first.
- States: IDLE → SETUP → CMD → TURN → DATA → HOLD → GAP → IDLE.
  - SETUP: cs=0, sclk=0, mosi=command bit 7; CLK_DIV cycles.
  - CMD/DATA: 8 bits each; per bit sclk high CLK_DIV cycles then low CLK_DIV cycles. mosi changes only on sclk falling edge (and on SETUP/TURN entry). miso sampled on the last clk cycle of each sclk-high phase, shifted in LSB side.
  - TURN: sclk=0, cs=0, mosi=data bit 7; TURN_CYC cycles.
  - HOLD: sclk=0, cs=0; CLK_DIV cycles.
  - GAP: cs=1, sclk=0, mosi=0; 2×CLK_DIV cycles; busy stays 1.
- Write: data byte on mosi = wdata; miso ignored; rdata unchanged.
- Read: data byte on mosi = 0x00; the 8 sampled miso bits load rdata in the cycle done pulses. Bits sampled during CMD are discarded.
- Reset mid-transaction: immediately cs=1, sclk=0, mosi=0, busy=0; no done pulse; rdata cleared to 0x00.
- Counters: half-period counter sized for CLK_DIV−1, bit counter 0–7, turn counter sized for TURN_CYC−1; no wrap beyond these bounds.

## Timing
- Accept edge = cycle 0; cs falls at cycle 1.
- done pulses (and cs rises) at cycle 1 + 34×CLK_DIV + TURN_CYC; defaults → cycle 145.
- busy falls 2×CLK_DIV cycles after done; defaults → cycle 153. Next start accepted on that cycle.
- rdata valid in the same cycle done=1.
- sclk duty 50%; sclk period = 2×CLK_DIV clk cycles; 16 rising sclk edges per transaction.

## Configuration
- SPI_MASTER_LOOPBACK_EN defined: miso input ignored; receive shifter samples internal mosi; read transactions drive wdata (not 0x00) in the data byte, so rdata = wdata. Pins behave otherwise identically.
- Undefined: normal operation as above; miso pin sampled.

## Test plan
- Reset: assert reset mid-idle and check sclk=0, cs=1, mosi=0, busy=0, done=0, rdata=0x00.
- Write addr=0x2A, wdata=0xC5, defaults → mosi bytes sampled on sclk rise 0x54 then 0xC5; exactly 16 sclk rises; done at cycle 145; busy low at cycle 153; rdata stays 0x00.
- Read addr=0x15 with slave model returning 0x3C on miso in data phase → command byte 0x2B, data-phase mosi 0x00, rdata=0x3C when done pulses.
- start held high through a whole write → exactly one transaction; second accepted no earlier than cycle 153.
- reset asserted at cycle 60 of a read → cs=1 and sclk=0 same cycle (asynchronous), no done, rdata=0x00; a fresh write then completes normally.
- With SPI_MASTER_LOOPBACK_EN: read with wdata=0xA7 and miso tied 0 → rdata=0xA7.
